// File: rtl/wb_gcd_master.sv
// wb_gcd_master: Wishbone classic initiator for the memory-mapped GCD slave.
// Per command it writes {a,b} as one word, polls with single-cycle read strobes
// until the slave acks a result, and returns bits [15:0] on the response port.
// Optional feature macro: WB_TIMEOUT_EN (aborts a stalled transaction after
// TIMEOUT_CYCLES bus cycles and reports rsp_err=1 with rsp_msg=0).
module wb_gcd_master #(
  parameter logic [31:0] GCD_ADDR = 32'h3000_0000
`ifdef WB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
  , parameter int unsigned TW = 8
`endif
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_val,
  input  logic        rsp_rdy,
  output logic [15:0] rsp_msg,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {
    IDLE, WR_STB, WR_WAIT, RD_STB, RD_WAIT, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] msg_q, msg_d;
  // Goes high on the first edge after reset release so cmd_rdy stays 0 in reset.
  logic        run_q;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^wbm_dat_i[31:16];

`ifdef WB_TIMEOUT_EN
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo;

  // cnt_q holds the bus cycles already completed, so the current cycle is number
  // cnt_q+1; >= keeps the abort reachable when the limit lands on a strobe cycle.
  assign tmo = (cnt_q >= TW'(TIMEOUT_CYCLES - 1));
`endif

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      msg_q   <= '0;
      run_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      msg_q   <= msg_d;
      run_q   <= 1'b1;
`ifdef WB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    msg_d     = msg_q;
    cmd_rdy   = 1'b0;
    rsp_val   = 1'b0;
    rsp_msg   = '0;
    rsp_err   = 1'b0;
    busy      = (state_q != IDLE);
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
`ifdef WB_TIMEOUT_EN
    err_d = err_q;
    cnt_d = cnt_q;
    if (state_q inside {WR_STB, WR_WAIT, RD_STB, RD_WAIT} && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        cmd_rdy = run_q;
        if (cmd_val && run_q) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          msg_d   = '0;
          state_d = WR_STB;
`ifdef WB_TIMEOUT_EN
          err_d = 1'b0;
          cnt_d = '0;
`endif
        end
      end
      WR_STB: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_dat_o = {a_q, b_q};
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        wbm_cyc_o = 1'b1;
        if (wbm_ack_i) begin
          state_d = RD_STB;
`ifdef WB_TIMEOUT_EN
        end else if (tmo) begin
          err_d   = 1'b1;
          msg_d   = '0;
          state_d = RESP;
`endif
        end else begin
          state_d = WR_STB;
        end
      end
      RD_STB: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        wbm_cyc_o = 1'b1;
        if (wbm_ack_i) begin
          msg_d   = wbm_dat_i[15:0];
          state_d = RESP;
`ifdef WB_TIMEOUT_EN
        end else if (tmo) begin
          err_d   = 1'b1;
          msg_d   = '0;
          state_d = RESP;
`endif
        end else begin
          state_d = RD_STB;
        end
      end
      RESP: begin
        rsp_val = 1'b1;
        rsp_msg = msg_q;
`ifdef WB_TIMEOUT_EN
        rsp_err = err_q;
`endif
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wbm_cyc_o) begin
      wbm_sel_o = 4'hF;
      wbm_adr_o = GCD_ADDR;
    end
  end

endmodule

// File: tb/tb_wb_gcd_master.sv
// Self-checking bench for wb_gcd_master: a GCD slave model on the bus, an
// expected-result queue filled from plain Euclid arithmetic on each accepted
// command, a per-cycle compare process, and directed scenarios with literals.
module tb_wb_gcd_master;
  localparam logic [31:0] ADDR = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        rsp_val;
  logic        rsp_rdy = 1'b1;
  logic [15:0] rsp_msg;
  logic        rsp_err;
  logic        busy;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i;
  logic        ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_gcd_master #(
    .GCD_ADDR(ADDR)
`ifdef WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
    , .TW(8)
`endif
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .rsp_val  (rsp_val),
    .rsp_rdy  (rsp_rdy),
    .rsp_msg  (rsp_msg),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack)
  );

  function automatic logic [15:0] gcd16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: registered ack one cycle after each strobe, optional refusals.
  int unsigned wr_nack = 0;
  int unsigned rd_nack = 0;
  bit          rd_never = 1'b0;
  int unsigned wr_seen, rd_seen;
  int unsigned enq_cnt = 0;
  logic [15:0] s_a, s_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack     <= 1'b0;
      dat_i   <= 32'hDEAD_BEEF;
      wr_seen <= 0;
      rd_seen <= 0;
    end else begin
      ack   <= 1'b0;
      dat_i <= 32'hDEAD_BEEF;
      if (!cyc) begin
        wr_seen <= 0;
        rd_seen <= 0;
      end else if (stb && we) begin
        wr_seen <= wr_seen + 1;
        if (wr_seen >= wr_nack) begin
          ack     <= 1'b1;
          s_a     <= dat_o[31:16];
          s_b     <= dat_o[15:0];
          enq_cnt <= enq_cnt + 1;
        end
      end else if (stb) begin
        rd_seen <= rd_seen + 1;
        if (!rd_never && rd_seen >= rd_nack) begin
          ack   <= 1'b1;
          dat_i <= {16'hC3C3, gcd16(s_a, s_b)};
        end
      end
    end
  end

  // Reference model state and per-cycle comparison.
  logic [15:0] expq[$];
  logic [31:0] exp_word = '0;
  logic [31:0] last_wdat = '0;
  int          wr_strobes = 0;
  int          rd_strobes = 0;
  logic        prev_stb = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {cmd_rdy, rsp_val, rsp_err, busy, cyc, stb, we,
                            |sel, |adr, |dat_o, |rsp_msg}, '0);
      expq.delete();
      prev_stb = 1'b0;
    end else begin
      if (cyc) chk("bus_addr_sel", {sel, adr}, {4'hF, ADDR});
      else     chk("bus_idle", {stb, we, |sel, |adr, |dat_o}, '0);
      if (stb) chk("stb_single_cycle", prev_stb, 1'b0);
      if (stb && we) begin
        wr_strobes++;
        last_wdat = dat_o;
        chk("wr_data", dat_o, exp_word);
      end
      if (stb && !we) begin
        rd_strobes++;
        chk("rd_data_zero", dat_o, '0);
      end
      chk("busy", busy, cyc | rsp_val);
      if (rsp_val) begin
        chk("rdy_in_resp", cmd_rdy, 1'b0);
        if (expq.size() == 0) begin
          chk("rsp_unexpected", rsp_val, 1'b0);
        end else begin
          if (rsp_err) chk("err_msg_zero", rsp_msg, '0);
          else         chk("rsp_msg", rsp_msg, expq[0]);
`ifndef WB_TIMEOUT_EN
          chk("err_tied_low", rsp_err, 1'b0);
`endif
          if (rsp_rdy) void'(expq.pop_front());
        end
      end else begin
        chk("idle_rsp_zero", {rsp_err, rsp_msg}, '0);
      end
      if (cmd_val && cmd_rdy) begin
        expq.push_back(gcd16(cmd_a, cmd_b));
        exp_word   = {cmd_a, cmd_b};
        wr_strobes = 0;
        rd_strobes = 0;
      end
      prev_stb = stb;
    end
  end

  // Issue one command; returns cycles from accept edge to first rsp_val and
  // the response seen on that cycle.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input int limit,
                         output int lat, output logic [15:0] msg, output logic err,
                         output logic cyc_at);
    bit acc;
    acc = 1'b0;
    lat = -1;
    msg = '0;
    err = 1'b0;
    cyc_at = 1'b0;
    @(posedge clk);
    #1;
    cmd_a = a;
    cmd_b = b;
    cmd_val = 1'b1;
    for (int i = 0; i < limit && !acc; i++) begin
      @(negedge clk);
      if (cmd_rdy) acc = 1'b1;
    end
    @(posedge clk);
    #1 cmd_val = 1'b0;
    chk("accepted", acc, 1'b1);
    if (acc) begin
      for (int k = 1; k <= limit; k++) begin
        @(negedge clk);
        if (rsp_val) begin
          lat = k;
          msg = rsp_msg;
          err = rsp_err;
          cyc_at = cyc;
          break;
        end
      end
      chk("rsp_seen", lat > 0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] msg;
    logic        err, cyc_at;
    int unsigned e0;
    int          nrsp;

    // Reset held three cycles, then ready one cycle after release.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_first_edge", cmd_rdy, 1'b0);
    @(negedge clk);
    chk("rdy_after_release", cmd_rdy, 1'b1);

    // Minimum latency, ready slave.
    run_cmd(16'd15, 16'd5, 50, lat, msg, err, cyc_at);
    chk("t2_latency", lat, 5);
    chk("t2_msg", msg, 16'd5);
    chk("t2_cyc_low", cyc_at, 1'b0);
    @(negedge clk);
    chk("t2_wdat", last_wdat, 32'h000F_0005);
    chk("t2_wr_strobes", wr_strobes, 1);
    chk("t2_rd_strobes", rd_strobes, 1);

    // Write refused three times.
    wr_nack = 3;
    e0 = enq_cnt;
    run_cmd(16'd48, 16'd18, 80, lat, msg, err, cyc_at);
    chk("t3_msg", msg, 16'd6);
    chk("t3_latency", lat, 11);
    @(negedge clk);
    chk("t3_wr_strobes", wr_strobes, 4);
    chk("t3_enqueued_once", enq_cnt - e0, 1);
    wr_nack = 0;

    // Read polled twice before result.
    rd_nack = 2;
    run_cmd(16'd1071, 16'd462, 80, lat, msg, err, cyc_at);
    chk("t3b_msg", msg, 16'd21);
    chk("t3b_latency", lat, 9);
    @(negedge clk);
    chk("t3b_rd_strobes", rd_strobes, 3);
    rd_nack = 0;

    // Operand boundaries.
    run_cmd(16'd0, 16'd0, 50, lat, msg, err, cyc_at);
    chk("gcd_0_0", msg, 16'd0);
    run_cmd(16'd0, 16'd7, 50, lat, msg, err, cyc_at);
    chk("gcd_0_7", msg, 16'd7);
    run_cmd(16'hFFFF, 16'hFFFF, 50, lat, msg, err, cyc_at);
    chk("gcd_ffff", msg, 16'hFFFF);
    @(negedge clk);
    chk("wdat_ffff", last_wdat, 32'hFFFF_FFFF);

    // Consumer back-pressure in RESP.
    rsp_rdy = 1'b0;
    run_cmd(16'd100, 16'd75, 50, lat, msg, err, cyc_at);
    chk("t4_msg", msg, 16'd25);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cmd_a = 16'd9;
      cmd_b = 16'd6;
      cmd_val = 1'b1;
      @(negedge clk);
      chk("t4_hold", {rsp_val, rsp_msg, cmd_rdy}, {1'b1, 16'd25, 1'b0});
    end
    @(posedge clk);
    #1 rsp_rdy = 1'b1;
    @(negedge clk);
    chk("t4_rdy_in_resp", cmd_rdy, 1'b0);
    @(negedge clk);
    chk("t4_back_idle", {cmd_rdy, rsp_val}, {1'b1, 1'b0});
    @(posedge clk);
    #1 cmd_val = 1'b0;
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (rsp_val) begin
        lat = k;
        msg = rsp_msg;
        break;
      end
    end
    chk("t4_second_latency", lat, 5);
    chk("t4_second_msg", msg, 16'd3);

`ifdef WB_TIMEOUT_EN
    // Read never acked: abort on the first wait cycle that reaches the limit.
    rd_never = 1'b1;
    run_cmd(16'd12, 16'd8, 100, lat, msg, err, cyc_at);
    chk("t5_latency", lat, 21);
    chk("t5_err", err, 1'b1);
    chk("t5_msg", msg, 16'd0);
    chk("t5_cyc_low", cyc_at, 1'b0);
    rd_never = 1'b0;
`endif

    // Asynchronous reset during RD_WAIT.
    rd_never = 1'b1;
    @(posedge clk);
    #1;
    cmd_a = 16'd30;
    cmd_b = 16'd20;
    cmd_val = 1'b1;
    @(negedge clk);
    chk("t6_ready", cmd_rdy, 1'b1);
    @(posedge clk);
    #1 cmd_val = 1'b0;
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (cyc && !stb && rd_strobes > 0) begin
        lat = k;
        break;
      end
    end
    chk("t6_reached_rd_wait", lat, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", {cyc, stb, rsp_val, busy, cmd_rdy}, '0);
    rd_never = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_val || cyc) nrsp++;
    end
    chk("t6_no_response", nrsp, 0);
    chk("t6_ready_after", cmd_rdy, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
